// File: rtl/minor_det2_unit_if.sv
// Element-fetch and result bundle between the minor unit and its requester / 3x3 stage.
// start is a request, accepted only while the unit is idle (busy=0, done=0); done pulses once per accepted start.
interface minor_det2_unit_if #(
   parameter int DW = 8,
   parameter int RW = 16
);
   logic          start;
   logic [1:0]    minor_idx;
   logic [3:0]    sel;
   logic [DW-1:0] k;
   logic          busy;
   logic          done;
   logic [RW-1:0] det_out;
   logic [2:0]    dbg_state;

   modport master (
      output start, minor_idx, k,
      input  sel, busy, done, det_out, dbg_state
   );

   modport slave (
      input  start, minor_idx, k,
      output sel, busy, done, det_out, dbg_state
   );
endinterface

// File: rtl/minor_det2_unit.sv
// 2x2 minor determinant: fetches four elements serially, then p0*p3 - p1*p2 on one shared multiplier.
// Optional MINOR_DET2_EARLY_ZERO_EN: skip the multiply when both products are trivially zero.
module minor_det2_unit #(
   parameter int DW = 8,
   parameter int RW = 16
) (
   input logic                clock,
   input logic                reset,
   minor_det2_unit_if.slave   bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      F0   = 3'd1,
      F1   = 3'd2,
      F2   = 3'd3,
      F3   = 3'd4,
      MUL1 = 3'd5,
      MUL2 = 3'd6,
      DONE = 3'd7
   } state_t;

   state_t               state;
   logic [1:0]           minor;
   logic [3:0]           sel_q;
   logic                 busy_q;
   logic                 done_q;
   logic signed [RW-1:0] det_q;
   logic [DW-1:0]        p0, p1, p2, p3;
   logic signed [RW-1:0] acc;
   logic signed [RW-1:0] mul_a, mul_b, prod;

   function automatic logic signed [RW-1:0] sext(input logic [DW-1:0] v);
      return {{(RW-DW){v[DW-1]}}, v};
   endfunction

   // Element index for fetch slot j of minor m; minor 3 reads index 15, which returns 0.
   function automatic logic [3:0] map_idx(input logic [1:0] m, input logic [1:0] j);
      logic [3:0] r;
      r = 4'hF;
      case (m)
         2'd0: case (j)
            2'd0: r = 4'd4;
            2'd1: r = 4'd5;
            2'd2: r = 4'd7;
            default: r = 4'd8;
         endcase
         2'd1: case (j)
            2'd0: r = 4'd3;
            2'd1: r = 4'd5;
            2'd2: r = 4'd6;
            default: r = 4'd8;
         endcase
         2'd2: case (j)
            2'd0: r = 4'd3;
            2'd1: r = 4'd4;
            2'd2: r = 4'd6;
            default: r = 4'd7;
         endcase
         default: r = 4'hF;
      endcase
      return r;
   endfunction

   always_comb begin
      mul_a = sext(p1);
      mul_b = sext(p2);
      if (state == MUL1) begin
         mul_a = sext(p0);
         mul_b = sext(p3);
      end
   end

   assign prod = mul_a * mul_b;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         minor  <= 2'd0;
         sel_q  <= 4'hF;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         det_q  <= '0;
         p0     <= '0;
         p1     <= '0;
         p2     <= '0;
         p3     <= '0;
         acc    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  minor  <= bus.minor_idx;
                  sel_q  <= map_idx(bus.minor_idx, 2'd0);
                  busy_q <= 1'b1;
                  state  <= F0;
               end
            end
            F0: begin
               p0    <= bus.k;
               sel_q <= map_idx(minor, 2'd1);
               state <= F1;
            end
            F1: begin
               p1    <= bus.k;
               sel_q <= map_idx(minor, 2'd2);
               state <= F2;
            end
            F2: begin
               p2    <= bus.k;
               sel_q <= map_idx(minor, 2'd3);
               state <= F3;
            end
            F3: begin
               p3    <= bus.k;
               sel_q <= 4'hF;
`ifdef MINOR_DET2_EARLY_ZERO_EN
               if ((p0 == '0 || bus.k == '0) && (p1 == '0 || p2 == '0)) begin
                  det_q  <= '0;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= DONE;
               end else begin
                  state <= MUL1;
               end
`else
               state <= MUL1;
`endif
            end
            MUL1: begin
               acc   <= prod;
               state <= MUL2;
            end
            MUL2: begin
               det_q  <= acc - prod;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= DONE;
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel       = sel_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.det_out   = det_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_minor_det2_unit.sv
// Self-checking bench for minor_det2_unit: models the 3x3 element store and scores each done result.
module tb_minor_det2_unit;

   logic clock;
   logic reset;

   minor_det2_unit_if #(.DW(8), .RW(16)) bus ();

   minor_det2_unit #(.DW(8), .RW(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  elem [9];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          errors = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // 3x3 stage model: element by index, 0 for any index past i.
   always_comb begin
      bus.k = 8'h00;
      if (bus.sel <= 4'd8) bus.k = elem[bus.sel];
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_sel(input logic [1:0] m, input int j);
      logic [3:0] t [4];
      case (m)
         2'd0: t = '{4'd4, 4'd5, 4'd7, 4'd8};
         2'd1: t = '{4'd3, 4'd5, 4'd6, 4'd8};
         2'd2: t = '{4'd3, 4'd4, 4'd6, 4'd7};
         default: t = '{4'hF, 4'hF, 4'hF, 4'hF};
      endcase
      return t[j];
   endfunction

   function automatic int val(input logic [3:0] s);
      if (s <= 4'd8) return int'($signed(elem[s]));
      return 0;
   endfunction

   function automatic logic [15:0] model_det(input logic [1:0] m);
      int a, b, c, d;
      a = val(exp_sel(m, 0));
      b = val(exp_sel(m, 1));
      c = val(exp_sel(m, 2));
      d = val(exp_sel(m, 3));
      return 16'(a * d - b * c);
   endfunction

   function automatic bit model_early(input logic [1:0] m);
      return (val(exp_sel(m, 0)) == 0 || val(exp_sel(m, 3)) == 0) &&
             (val(exp_sel(m, 1)) == 0 || val(exp_sel(m, 2)) == 0);
   endfunction

   task automatic load_seq();
      for (int i = 0; i < 9; i++) elem[i] = 8'(i + 1);
   endtask

   // Scoreboard: every done pops one expected result.
   always @(negedge clock) begin
      if (reset && bus.done) begin
         if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
         else check("det_out", 32'(bus.det_out), 32'(exp_q.pop_front()));
      end
   end

   task automatic run_minor(input logic [1:0] m, input bit pulse_extra);
      logic [15:0] e;
      logic [7:0]  saved [9];
      int          exp_lat;
      int          lat;
      bit          seen;
      e = model_det(m);
      exp_lat = 7;
`ifdef MINOR_DET2_EARLY_ZERO_EN
      if (model_early(m)) exp_lat = 5;
`endif
      exp_q.push_back(e);
      saved = elem;
      @(negedge clock);
      bus.start = 1'b1;
      bus.minor_idx = m;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      bus.minor_idx = 2'($urandom_range(0, 3));
      seen = 1'b0;
      lat = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clock);
         if (c <= 4) check("sel", 32'(bus.sel), 32'(exp_sel(m, c - 1)));
         if (c == 1) check("busy_run", 32'(bus.busy), 32'd1);
         if (pulse_extra && c == 3) bus.start = 1'b1;
         if (pulse_extra && c == 4) bus.start = 1'b0;
         if (c == 5) for (int i = 0; i < 9; i++) elem[i] = 8'($urandom_range(0, 255));
         if (bus.done) begin
            seen = 1'b1;
            lat = c;
            check("busy_at_done", 32'(bus.busy), 32'd0);
         end
      end
      elem = saved;
      check("latency", 32'(lat), 32'(exp_lat));
      if (pulse_extra) bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      check("done_width", 32'(bus.done), 32'd0);
      check("det_hold", 32'(bus.det_out), 32'(e));
      if (pulse_extra) begin
         for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("ignored_start_busy", 32'(bus.busy), 32'd0);
         end
         check("ignored_start_hold", 32'(bus.det_out), 32'(e));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      bus.start = 1'b0;
      bus.minor_idx = 2'd0;
      for (int i = 0; i < 9; i++) elem[i] = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_det", 32'(bus.det_out), 32'd0);
      check("rst_sel", 32'(bus.sel), 32'hF);
      reset = 1'b1;

      // Idle after reset release, no start.
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         check("idle_det", 32'(bus.det_out), 32'd0);
         check("idle_done", 32'(bus.done), 32'd0);
         check("idle_busy", 32'(bus.busy), 32'd0);
         check("idle_sel", 32'(bus.sel), 32'hF);
      end

      load_seq();
      run_minor(2'd0, 1'b0);
      run_minor(2'd1, 1'b0);
      run_minor(2'd2, 1'b0);

      // Extremes on minor 1: d,f,g,i.
      elem[3] = 8'h80; elem[8] = 8'h7F; elem[5] = 8'h7F; elem[6] = 8'h80;
      run_minor(2'd1, 1'b0);
      elem[3] = 8'h80; elem[8] = 8'h80; elem[5] = 8'h7F; elem[6] = 8'h80;
      run_minor(2'd1, 1'b0);

      // Start pulsed in F2 and in DONE.
      load_seq();
      run_minor(2'd0, 1'b1);

      // Reset dropped in MUL1 aborts with no done.
      elem[3] = 8'h80; elem[8] = 8'h80; elem[5] = 8'h7F; elem[6] = 8'h80;
      run_minor(2'd1, 1'b0);
      @(negedge clock);
      bus.start = 1'b1;
      bus.minor_idx = 2'd0;
      @(posedge clock);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clock);
      reset = 1'b0;
      #1;
      check("abort_det", 32'(bus.det_out), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_sel", 32'(bus.sel), 32'hF);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clock);
         check("abort_no_done", 32'(bus.done), 32'd0);
      end

      // Invalid minor reads nothing and yields 0.
      load_seq();
      run_minor(2'd3, 1'b0);

      // Random matrices and minors, with occasional zeros.
      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 9; i++)
            elem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         run_minor(2'($urandom_range(0, 3)), 1'b0);
      end

      repeat (3) @(negedge clock);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
